muldiv_iter: RTL
================

// Module: muldiv_iter
// PURPOSE
//  Iterative RV32M multiply/divide unit. It is the external M-extension engine that sits directly
//  downstream of the execute stage when __RV32_M_EXTERNAL is defined.
//  EX drives a one-cycle start pulse with latched operands and funct3. This block returns the
//  result with a one-cycle acknowledge, and EX stalls until that acknowledge.
//  The datapath is one shared shift/add-subtract engine, one bit per cycle, operating on magnitudes.
// PARAMETERS
//  XLEN  32  operand/result width; the iteration count equals XLEN
// PORTS
//  i_clk  in   1     clock, all state updates on rising edge
//  i_rst  in   1     reset, synchronous, active-low
//  i_en   in   1     start pulse, one cycle; sampled only in IDLE
//  i_rs1  in   XLEN  operand A (multiplicand / dividend)
//  i_rs2  in   XLEN  operand B (multiplier / divisor)
//  i_f3   in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  o_res  out  XLEN  result; valid while o_ack=1, held until the next accepted start
//  o_ack  out  1     result-valid pulse, exactly one cycle per accepted start
// BEHAVIOUR
//  Reset (i_rst=0 at a clock edge):
//   - state goes to IDLE; o_ack=0, o_res=0, all internal registers cleared
//   - takes priority in every state; an in-flight operation is dropped and produces no ack
//  FSM states: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   - IDLE: i_en=1 captures operands, f3, sign flags and magnitudes.
//     - Normal operation: go to CALC with the counter at XLEN-1.
//     - Division special cases: go straight to FIX.
//   - CALC: one iteration per cycle. The counter decrements, and state goes to FIX after the
//     counter-0 iteration. CALC lasts exactly XLEN cycles.
//   - FIX: apply sign correction and select the result field into the result register.
//   - DONE: o_ack=1 for one cycle, then return to IDLE.
//  Signedness:
//   - rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 is signed for MUL/MULH/DIV/REM.
//   - MULHU, DIVU and REMU treat both operands as unsigned.
//   - The engine works on |a| and |b|, each XLEN bits unsigned.
//   - |0x80000000| is 0x80000000 taken as unsigned.
//  Multiply:
//   - Engine: 2*XLEN product register, shift-add.
//   - Negate the full 2*XLEN product in FIX when sign(a)^sign(b).
//   - MUL returns bits [XLEN-1:0]; MULH, MULHSU and MULHU return bits [2*XLEN-1:XLEN].
//  Divide:
//   - Engine: restoring division with an XLEN+1 bit partial remainder.
//   - Quotient is negated when sign(a)^sign(b); remainder takes the sign of the dividend.
//  Division special cases (detected in IDLE, no CALC):
//   - divisor=0: quotient = all ones, remainder = rs1 unmodified.
//   - signed DIV/REM with rs1=0x80000000 and rs2=-1: quotient=0x80000000, remainder=0.
//  Latency (i_en sampled in cycle 0):
//   - normal operation: o_ack=1 in cycle XLEN+2 (34 when XLEN=32)
//   - special cases: o_ack=1 in cycle 2
//   - next start is accepted no earlier than cycle XLEN+3; throughput is 1 op per XLEN+3 cycles
//  Handshake:
//   - i_en outside IDLE, including the DONE cycle, is ignored. No queueing, no error.
//   - Operands may change after the start cycle; they are captured in IDLE.
//   - o_res stays stable from the ack cycle until the next accepted i_en.
// TESTING
//  1. MUL 7 * 0xFFFFFFFD: i_en in cycle 0 -> o_res=0xFFFFFFEB with o_ack=1 in cycle 34 only.
//  2. MULH 0x80000000 * 0x80000000 -> 0x40000000.
//     MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
//     MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
//  3. DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 % 7 -> 2.
//  4. DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, each acked in cycle 2.
//     DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
//     REM 0x80000000 / 0xFFFFFFFF -> 0, acked in cycle 2.
//  5. i_en re-pulsed in cycles 5 and 34 (DONE) -> ignored: exactly one ack, o_res unchanged.
//     A new i_en in cycle 35 is accepted.
//  6. Reset mid-op: i_rst=0 in cycle 10 of a DIV -> o_ack never asserts and o_res=0.
//     A fresh MUL 3*4 started after reset -> 12 in cycle 34 relative to its start.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit. One shared shift/add-subtract engine
// processes one bit per cycle on operand magnitudes, then applies sign fix-up.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_f3,
  output logic [XLEN-1:0] o_res,
  output logic            o_ack
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Handshake: i_en is a one-cycle start accepted only in S_IDLE; o_ack is high
  // for exactly the S_DONE cycle and o_res holds until the next fix-up.
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   hi_q;
  logic [XLEN-1:0] lo_q, a_q, b_q, a_raw_q, res_q;
  logic [2:0]      f3_q;
  logic            neg_q, sa_q, div0_q, ovf_q;

  // Operand decode, used only when a start is accepted
  logic            is_div_in, signed_a, signed_b, sa_in, sb_in, div0_in, ovf_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;

  always_comb begin
    is_div_in = i_f3[2];
    signed_a  = i_f3[2] ? ~i_f3[0] : (i_f3 != 3'b011);
    signed_b  = i_f3[2] ? ~i_f3[0] : ~i_f3[1];
    sa_in     = signed_a & i_rs1[XLEN-1];
    sb_in     = signed_b & i_rs2[XLEN-1];
    a_mag_in  = sa_in ? -i_rs1 : i_rs1;
    b_mag_in  = sb_in ? -i_rs2 : i_rs2;
    div0_in   = is_div_in & (i_rs2 == '0);
    ovf_in    = is_div_in & ~i_f3[0] & (i_rs1 == MIN_NEG) & (i_rs2 == '1);
  end

  // Engine step: shift-add for multiply, restoring subtract for divide
  logic [XLEN:0] mul_sum, div_sh, div_diff;
  logic          div_ge;

  always_comb begin
    mul_sum  = {1'b0, hi_q[XLEN-1:0]} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_sh   = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, b_q});
    div_diff = div_sh - {1'b0, b_q};
  end

  // Sign correction and field selection
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    prod   = {hi_q[XLEN-1:0], lo_q};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -lo_q : lo_q;
    rem    = sa_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];
    case (f3_q)
      3'b000:         fix_res = prod_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         fix_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: fix_res = div0_q ? '1 : (ovf_q ? MIN_NEG : quo);
      default:        fix_res = div0_q ? a_raw_q : (ovf_q ? '0 : rem);
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_en) state_d = (div0_in | ovf_in) ? S_FIX : S_CALC;
      S_CALC: if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      a_raw_q <= '0;
      res_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (i_en) begin
          a_q     <= a_mag_in;
          b_q     <= b_mag_in;
          a_raw_q <= i_rs1;
          f3_q    <= i_f3;
          sa_q    <= sa_in;
          neg_q   <= sa_in ^ sb_in;
          div0_q  <= div0_in;
          ovf_q   <= ovf_in;
          cnt_q   <= CW'(XLEN-1);
          hi_q    <= '0;
          lo_q    <= is_div_in ? a_mag_in : b_mag_in;
        end
        S_CALC: begin
          cnt_q <= cnt_q - 1'b1;
          if (f3_q[2]) begin
            hi_q <= div_ge ? div_diff : div_sh;
            lo_q <= {lo_q[XLEN-2:0], div_ge};
          end else begin
            hi_q <= {1'b0, mul_sum[XLEN:1]};
            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
          end
        end
        S_FIX: res_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign o_ack = (state_q == S_DONE);
  assign o_res = res_q;

endmodule
